// File: rtl/rv32_inst_encoder.sv
// RV32I instruction assembler: packs decoded fields into 32-bit words and streams them out through a 2-entry FIFO.
// Optional macro ENC_RANGE_CHECK_EN additionally flags immediates that do not fit their format.
module rv32_inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [31:0]       count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [31:0]       enc_inst;
    logic              enc_err;
    logic              range_bad;

    logic [31:0]       mem_inst [2];
    logic [ADDR_W-1:0] mem_addr [2];
    logic              mem_err  [2];
    logic [1:0]        occ;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [ADDR_W-1:0] addr_cnt;
    logic              push;
    logic              pop;

    always_comb begin
        enc_inst = 32'h0000_0000;
        enc_err  = 1'b0;
        case (in_fmt)
            FMT_R: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc_inst = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: enc_err = 1'b1;
        endcase
        enc_err = enc_err | range_bad;
    end

`ifdef ENC_RANGE_CHECK_EN
    // A value fits N signed bits when every bit above bit N-1 equals the sign bit.
    always_comb begin
        range_bad = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: range_bad = ~(&in_imm[31:11] | ~|in_imm[31:11]);
            FMT_B:        range_bad = ~(&in_imm[31:12] | ~|in_imm[31:12]) | in_imm[0];
            FMT_J:        range_bad = ~(&in_imm[31:20] | ~|in_imm[31:20]) | in_imm[0];
            FMT_U:        range_bad = |in_imm[11:0];
            default:      range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    assign out_inst = mem_inst[rd_ptr];
    assign out_addr = mem_addr[rd_ptr];
    assign out_err  = mem_err[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_inst[i] <= 32'h0000_0000;
                mem_addr[i] <= BASE_ADDR;
                mem_err[i]  <= 1'b0;
            end
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            addr_cnt <= BASE_ADDR;
            count    <= 32'd0;
        end else if (flush) begin
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            addr_cnt <= BASE_ADDR;
            count    <= 32'd0;
        end else begin
            if (push) begin
                mem_inst[wr_ptr] <= enc_inst;
                mem_addr[wr_ptr] <= addr_cnt;
                mem_err[wr_ptr]  <= enc_err;
                wr_ptr           <= ~wr_ptr;
                addr_cnt         <= addr_cnt + ADDR_W'(4);
                count            <= count + 32'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Directed self-checking bench for rv32_inst_encoder: encoding table plus backpressure, flush and reset sequences.
module tb_rv32_inst_encoder;

`ifdef ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [31:0] count;

    int checks = 0;
    int errors = 0;

    rv32_inst_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm,
                                 input logic [31:0] exp_inst, input logic exp_err);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.exp_inst = exp_inst; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
    endtask

    // Called at a negedge; the bundle is taken on the following posedge.
    task automatic push(input vec_t v);
        drive(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl [12];
    vec_t seq [3];
    logic [31:0] exp_addr [3];
    int idx;
    logic c_acc;

    initial begin
        tbl[0]  = mkv(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h0050_0093, 1'b0);
        tbl[1]  = mkv(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020_A423, 1'b0);
        tbl[2]  = mkv(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        tbl[3]  = mkv(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        tbl[4]  = mkv(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h20, 32'd5,        32'h0000_0000, 1'b1);
        tbl[5]  = mkv(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h8000_0093, RC);
        tbl[6]  = mkv(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h0020_81B3, 1'b0);
        tbl[7]  = mkv(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        tbl[8]  = mkv(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5678, 32'h1234_52B7, RC);
        tbl[9]  = mkv(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h00, 32'h0000_0403, 32'h4031_5093, 1'b0);
        tbl[10] = mkv(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h0000_0263, RC);
        tbl[11] = mkv(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_F800, 32'h0000_0000, 1'b1);

        do_reset();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_addr", out_addr, BASE);
        check("reset count", count, 32'd0);

        // Table phase: consumer always ready, each word checked one cycle after accept.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d out_inst", i), out_inst, tbl[i].exp_inst);
            check($sformatf("vec%0d out_err", i), 32'(out_err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d out_addr", i), out_addr, BASE + 32'(4 * i));
        end
        @(negedge clk);
        check("table count", count, 32'd12);
        check("table drained", 32'(out_valid), 32'd0);

        // Backpressure: three bundles, buffer holds two.
        seq[0] = tbl[0]; seq[1] = tbl[1]; seq[2] = tbl[2];
        exp_addr[0] = BASE; exp_addr[1] = BASE + 32'd4; exp_addr[2] = BASE + 32'd8;
        do_reset();
        out_ready = 1'b0;
        push(seq[0]);
        @(negedge clk);
        check("bp in_ready after 1", 32'(in_ready), 32'd1);
        push(seq[1]);
        @(negedge clk);
        check("bp in_ready after 2", 32'(in_ready), 32'd0);
        drive(seq[2]);
        repeat (2) @(negedge clk);
        check("bp in_ready held low", 32'(in_ready), 32'd0);
        check("bp held inst", out_inst, seq[0].exp_inst);
        check("bp held addr", out_addr, BASE);
        check("bp count", count, 32'd2);
        out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 10 && idx < 3; cyc++) begin
            if (out_valid) begin
                check($sformatf("bp word%0d inst", idx), out_inst, seq[idx].exp_inst);
                check($sformatf("bp word%0d addr", idx), out_addr, exp_addr[idx]);
                idx++;
            end
            c_acc = in_valid & in_ready;
            @(posedge clk);
            #1 if (c_acc) in_valid = 1'b0;
            @(negedge clk);
        end
        check("bp words drained", 32'(idx), 32'd3);
        check("bp final count", count, 32'd3);
        in_valid = 1'b0;

        // Flush with an accept in the same cycle: flush wins.
        do_reset();
        out_ready = 1'b0;
        push(tbl[6]);
        @(negedge clk);
        push(tbl[7]);
        @(negedge clk);
        drive(tbl[3]);
        flush = 1'b1;
        @(posedge clk);
        #1 begin flush = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush count", count, 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        push(tbl[3]);
        @(negedge clk);
        check("post-flush out_valid", 32'(out_valid), 32'd1);
        check("post-flush addr", out_addr, BASE);
        check("post-flush inst", out_inst, tbl[3].exp_inst);
        check("post-flush count", count, 32'd1);

        // Asynchronous reset with two words buffered.
        @(negedge clk);
        out_ready = 1'b0;
        push(tbl[9]);
        @(negedge clk);
        push(tbl[4]);
        @(negedge clk);
        check("pre-rst out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_inst", out_inst, 32'd0);
        check("rst out_addr", out_addr, BASE);
        check("rst out_err", 32'(out_err), 32'd0);
        check("rst count", count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("rst no output", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
